ifetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the instruction decoder. It owns the program counter and issues one word-aligned read at a time to instruction memory over a valid/ready request channel. It registers the returned 32-bit instruction, with its PC, for the decoder. Taken-branch redirects from the execute side kill any in-flight fetch and restart fetching at the target.

---
 rtl/ifetch_pkg.sv | 25 ++
 rtl/ifetch_pc_next.sv | 16 +
 rtl/ifetch_unit.sv | 96 +++++++++
 tb/tb_ifetch_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction fetch stage.
package ifetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        FULL
    } state_t;

    typedef enum logic [1:0] {
        SEL_HOLD,
        SEL_INC,
        SEL_REDIR
    } pc_sel_t;

    localparam int          INST_W     = 32;
    localparam logic [31:0] PC_INC     = 32'd4;
    localparam logic [INST_W-1:0] RESET_INST = 32'h0;

    function automatic logic [31:0] align(input logic [31:0] a);
        return a & ~32'h3;
    endfunction

endpackage

// File: rtl/ifetch_pc_next.sv
// pc_next: next program counter select (hold, sequential, redirect).
// Sequential increment wraps naturally modulo 2^32.
module pc_next
    import ifetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] target,
    input  pc_sel_t     sel,
    output logic [31:0] pc_nxt
);

    assign pc_nxt = (sel == SEL_REDIR) ? align(target) :
                    (sel == SEL_INC)   ? align(pc) + PC_INC :
                                         pc;

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: single-outstanding instruction fetch with redirect and drop of stale responses.
// All decoder-facing outputs are registered; the request channel is decoded from state and pc.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    output logic [31:0]       imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    output logic [INST_W-1:0] inst,
    output logic [31:0]       inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_target
);

    state_t      state, state_nxt;
    pc_sel_t     sel;
    logic [31:0] pc, pc_nxt_w;
    logic        drop, drop_nxt, load, clr_valid;

    pc_next u_pc_next (
        .pc     (pc),
        .target (redirect_target),
        .sel    (sel),
        .pc_nxt (pc_nxt_w)
    );

    always_comb begin
        state_nxt = state;
        drop_nxt  = drop;
        sel       = redirect_valid ? SEL_REDIR : SEL_HOLD;
        load      = 1'b0;
        clr_valid = redirect_valid;
        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                if (imem_req_ready) begin
                    state_nxt = WAIT;
                    drop_nxt  = redirect_valid;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    drop_nxt = 1'b0;
                    if (drop || redirect_valid) begin
                        state_nxt = REQ;
                    end else begin
                        load      = 1'b1;
                        sel       = SEL_INC;
                        state_nxt = FULL;
                    end
                end else if (redirect_valid) begin
                    drop_nxt = 1'b1;
                end
            end
            FULL: begin
                if (redirect_valid || inst_ready) begin
                    clr_valid = 1'b1;
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            drop       <= 1'b0;
            inst       <= RESET_INST;
            inst_pc    <= 32'h0;
            inst_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt_w;
            drop       <= drop_nxt;
            inst_valid <= load | (inst_valid & ~clr_valid);
            if (load) begin
                inst    <= imem_rsp_data;
                inst_pc <= pc;
            end
        end
    end

    assign imem_req_valid = (state == REQ);
    assign imem_req_addr  = pc;

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed and randomized checks of ifetch_unit against a transaction-level model.
module tb_ifetch_unit;

    localparam logic [31:0] RPC = 32'h0000_0040;
    localparam logic [31:0] KEY = 32'h5A5A_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic [31:0] imem_req_addr, imem_rsp_data;
    logic [31:0] inst, inst_pc;
    logic        inst_valid, inst_ready, redirect_valid;
    logic [31:0] redirect_target;

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    // model: fetch pointer, outstanding request, stale flag, one-entry buffer
    bit          m_fresh, m_out, m_kill, m_bv, m_acc;
    logic [31:0] m_pc, m_bd, m_bp;

    bit          mem_pend;
    int          mem_cnt;
    logic [31:0] mem_dat, force_dat;
    int          lat_lo = 1, lat_hi = 1, rdy_pct = 100, spur_pct = 0;
    bit          rnd_data = 1'b0, force_en = 1'b0;

    logic [31:0] sp, sd;

    always #5 clk = ~clk;

    ifetch_unit #(.RESET_PC(RPC)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fresh = 1'b1;
        m_out   = 1'b0;
        m_kill  = 1'b0;
        m_bv    = 1'b0;
        m_acc   = 1'b0;
        m_pc    = RPC;
        m_bd    = 32'h0;
        m_bp    = 32'h0;
    endtask

    task automatic model_step();
        bit take;
        m_acc   = !m_fresh && !m_out && !m_bv && imem_req_ready;
        take    = m_out && imem_rsp_valid;
        m_fresh = 1'b0;
        if (m_bv && inst_ready) m_bv = 1'b0;
        if (take) begin
            m_out = 1'b0;
            if (!m_kill && !redirect_valid) begin
                m_bd = imem_rsp_data;
                m_bp = m_pc;
                m_bv = 1'b1;
                m_pc = m_pc + 32'd4;
            end
            m_kill = 1'b0;
        end
        if (m_acc) begin
            m_out  = 1'b1;
            m_kill = 1'b0;
        end
        if (redirect_valid) begin
            m_pc = redirect_target & ~32'h3;
            m_bv = 1'b0;
            if (m_out) m_kill = 1'b1;
        end
    endtask

    task automatic drive_mem();
        imem_req_ready = ($urandom_range(99, 0) < rdy_pct);
        imem_rsp_valid = mem_pend ? (mem_cnt == 0) : ($urandom_range(99, 0) < spur_pct);
        imem_rsp_data  = (mem_pend && mem_cnt == 0) ? mem_dat : $urandom;
    endtask

    task automatic tick();
        logic [31:0] a;
        @(posedge clk);
        #1;
        a = m_pc;
        if (!rst_n) model_reset();
        else model_step();
        if (mem_pend && imem_rsp_valid) mem_pend = 1'b0;
        else if (mem_pend && mem_cnt > 0) mem_cnt--;
        if (m_acc) begin
            mem_pend = 1'b1;
            mem_cnt  = int'($urandom_range(lat_hi, lat_lo)) - 1;
            mem_dat  = force_en ? force_dat : rnd_data ? $urandom : a ^ KEY;
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        drive_mem();
    endtask

    task automatic wait_req();
        for (int i = 0; i < 50 && !imem_req_valid; i++) tick();
        chk("wait_req", 32'(imem_req_valid), 32'd1);
    endtask

    task automatic wait_inst();
        for (int i = 0; i < 50 && !inst_valid; i++) tick();
        chk("wait_inst", 32'(inst_valid), 32'd1);
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("req_valid", 32'(imem_req_valid), 32'(!m_fresh && !m_out && !m_bv));
            chk("req_addr", imem_req_addr, m_pc);
            chk("inst_valid", 32'(inst_valid), 32'(m_bv));
            chk("inst", inst, m_bd);
            chk("inst_pc", inst_pc, m_bp);
        end
    end

    initial begin
        rst_n = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = 32'h0;
        inst_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 32'h0;
        mem_pend = 1'b0;
        mem_cnt = 0;
        model_reset();
        chk_on = 1'b1;
        repeat (2) tick();
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr", imem_req_addr, RPC);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);

        // straight-line fetch: one instruction every third cycle
        #2 rst_n = 1'b1;
        chk("idle_req_valid", 32'(imem_req_valid), 32'd0);
        inst_ready = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 1) chk("first_req_addr", imem_req_addr, RPC);
            chk("seq_valid", 32'(inst_valid), 32'(k % 3 == 0));
            if (k % 3 == 0) begin
                chk("seq_pc", inst_pc, RPC + 32'(4 * (k / 3 - 1)));
                chk("seq_data", inst, (RPC + 32'(4 * (k / 3 - 1))) ^ KEY);
            end
        end

        // decoder stall holds the instruction and blocks new requests
        inst_ready = 1'b0;
        sp = inst_pc;
        sd = inst;
        repeat (5) begin
            tick();
            chk("stall_pc", inst_pc, sp);
            chk("stall_inst", inst, sd);
            chk("stall_noreq", 32'(imem_req_valid), 32'd0);
        end
        inst_ready = 1'b1;
        tick();
        chk("unstall_valid", 32'(inst_valid), 32'd0);
        chk("unstall_req", 32'(imem_req_valid), 32'd1);
        chk("unstall_addr", imem_req_addr, sp + 32'd4);

        // redirect while waiting: the late response is dropped
        lat_lo = 4; lat_hi = 4;
        force_en = 1'b1; force_dat = 32'hDEAD_BEEF;
        tick();
        redirect_valid = 1'b1; redirect_target = 32'h0000_0103;
        tick();
        for (int i = 0; i < 20 && !imem_req_valid; i++) begin
            chk("drop_no_inst", 32'(inst_valid), 32'd0);
            tick();
        end
        chk("drop_req_addr", imem_req_addr, 32'h0000_0100);
        force_en = 1'b0; lat_lo = 1; lat_hi = 1;
        wait_inst();
        chk("drop_first_pc", inst_pc, 32'h0000_0100);
        chk("drop_first_inst", inst, 32'h0000_0100 ^ KEY);

        // redirect coinciding with response and consume
        wait_req();
        tick();
        redirect_valid = 1'b1; redirect_target = 32'h0000_0200; inst_ready = 1'b1;
        tick();
        chk("coinc_valid", 32'(inst_valid), 32'd0);
        chk("coinc_req", 32'(imem_req_valid), 32'd1);
        chk("coinc_addr", imem_req_addr, 32'h0000_0200);
        wait_inst();
        chk("coinc_pc", inst_pc, 32'h0000_0200);

        // wrap at the top of the address space, with an unaligned target
        inst_ready = 1'b0;
        redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFE;
        tick();
        chk("wrap_top_addr", imem_req_addr, 32'hFFFF_FFFC);
        chk("wrap_flush", 32'(inst_valid), 32'd0);
        inst_ready = 1'b1;
        wait_inst();
        chk("wrap_top_pc", inst_pc, 32'hFFFF_FFFC);
        wait_req();
        chk("wrap_zero_addr", imem_req_addr, 32'h0000_0000);

        // reset mid-request, then a late response in the idle cycle
        lat_lo = 10; lat_hi = 10;
        tick();
        tick();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_inst", inst, 32'h0);
        chk("mid_rst_valid", 32'(imem_req_valid), 32'd0);
        repeat (2) tick();
        mem_cnt = 0;
        drive_mem();
        #2 rst_n = 1'b1;
        chk("late_idle_req", 32'(imem_req_valid), 32'd0);
        lat_lo = 1; lat_hi = 1;
        tick();
        chk("late_req", 32'(imem_req_valid), 32'd1);
        chk("late_addr", imem_req_addr, RPC);
        chk("late_ignored", 32'(inst_valid), 32'd0);
        wait_inst();
        chk("restart_pc", inst_pc, RPC);
        chk("restart_inst", inst, RPC ^ KEY);

        // randomized traffic
        rnd_data = 1'b1; rdy_pct = 70; spur_pct = 10; lat_lo = 1; lat_hi = 4;
        for (int c = 0; c < 3000; c++) begin
            inst_ready = ($urandom_range(99, 0) < 70);
            if ($urandom_range(99, 0) < 8) begin
                redirect_valid = 1'b1;
                redirect_target = ($urandom_range(3, 0) == 0) ?
                    {28'hFFF_FFFF, 4'($urandom_range(15, 0))} : $urandom;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
